// File: rtl/rx_fcs_check.sv
// Receive FCS checker/stripper: payload out 1 cycle after the byte that pushes it, verdict 1 cycle after i_last.
// No backpressure; i_valid low simply freezes all frame state.
`timescale 1ns/1ps
module rx_fcs_check #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic             i_error,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_status_valid,
  output logic             o_fcs_ok,
  output logic             o_len_err,
  output logic             o_rx_err,
  output logic [LEN_W-1:0] o_frame_len,
  output logic [15:0]      o_bad_count
);

  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]      POLY     = 32'hEDB8_8320;
  localparam logic [31:0]      RESIDUE  = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_FRAME);

  // Bit-serial form of one table step; unrolls to the usual XOR network.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [2:0]       occ;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_next;
  logic             err;
  logic             err_next;
  logic [31:0]      hold;
  logic             push;
  logic             fcs_ok_next;
  logic             len_err_next;
  logic             frame_bad;

  always_comb begin
    crc_next     = crc_byte(crc, i_data);
    len_next     = (&len) ? len : len + LEN_W'(1);
    err_next     = err | i_error;
    push         = i_valid && (occ == 3'd4);
    fcs_ok_next  = (crc_next == RESIDUE);
    len_err_next = (len_next < MIN_L) || (len_next > MAX_L);
    frame_bad    = !fcs_ok_next || len_err_next || err_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      crc            <= CRC_INIT;
      occ            <= 3'd0;
      len            <= '0;
      err            <= 1'b0;
      hold           <= 32'h0;
      o_data         <= 8'h00;
      o_valid        <= 1'b0;
      o_last         <= 1'b0;
      o_status_valid <= 1'b0;
      o_fcs_ok       <= 1'b0;
      o_len_err      <= 1'b0;
      o_rx_err       <= 1'b0;
      o_frame_len    <= '0;
      o_bad_count    <= 16'h0000;
    end else begin
      o_valid        <= push;
      o_last         <= push && i_last;
      o_status_valid <= i_valid && i_last;
      // hold[31:24] is the oldest byte; once four are held it is payload, not FCS
      if (push) o_data <= hold[31:24];
      if (i_valid) begin
        hold <= {hold[23:0], i_data};
        if (i_last) begin
          crc         <= CRC_INIT;
          occ         <= 3'd0;
          len         <= '0;
          err         <= 1'b0;
          o_fcs_ok    <= fcs_ok_next;
          o_len_err   <= len_err_next;
          o_rx_err    <= err_next;
          o_frame_len <= len_next;
          if (frame_bad && (o_bad_count != 16'hFFFF)) o_bad_count <= o_bad_count + 16'd1;
        end else begin
          crc <= crc_next;
          len <= len_next;
          err <= err_next;
          if (occ != 3'd4) occ <= occ + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_fcs_check.sv
// Bench for rx_fcs_check: directed and random frame streams against a frame-level model.
`timescale 1ns/1ps
module tb_rx_fcs_check;
  localparam int MINF = 64;
  localparam int MAXF = 1518;
  localparam int LW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    din;
  logic          vin, lin, ein;
  logic [7:0]    o_data;
  logic          o_valid, o_last, o_status_valid, o_fcs_ok, o_len_err, o_rx_err;
  logic [LW-1:0] o_frame_len;
  logic [15:0]   o_bad_count;

  always #5 clk = ~clk;

  rx_fcs_check #(.MIN_FRAME(MINF), .MAX_FRAME(MAXF), .LEN_W(LW)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid(vin), .i_last(lin), .i_error(ein),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_status_valid(o_status_valid),
    .o_fcs_ok(o_fcs_ok), .o_len_err(o_len_err), .o_rx_err(o_rx_err),
    .o_frame_len(o_frame_len), .o_bad_count(o_bad_count)
  );

  int checks = 0;
  int failures = 0;
  int model_bad = 0;
  logic [31:0] tbl [256];
  logic [7:0]  frm [$];
  // input stream: one entry per cycle
  logic [7:0]  s_dat [$];
  bit          s_vld [$], s_lst [$], s_err [$];
  // observed outputs
  logic [7:0]  g_dat [$];
  bit          g_lst [$], g_ok [$], g_le [$], g_rx [$], g_co [$];
  int          g_len [$];

  always @(negedge clk) begin
    if (o_valid) begin
      g_dat.push_back(o_data);
      g_lst.push_back(o_last);
    end
    if (o_status_valid) begin
      g_ok.push_back(o_fcs_ok);
      g_le.push_back(o_len_err);
      g_rx.push_back(o_rx_err);
      g_len.push_back(int'(o_frame_len));
      g_co.push_back(o_last && o_valid);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fcs_q(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) c = (c >> 8) ^ tbl[c[7:0] ^ q[k]];
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = fcs_q(frm, frm.size());
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  // Copies frm into the stream; an optional idle cycle with junk flags before index gap_at.
  task automatic append_frm(input int err_at, input int gap_at);
    for (int k = 0; k < frm.size(); k++) begin
      if (k == gap_at) begin
        s_dat.push_back(8'($urandom)); s_vld.push_back(1'b0);
        s_lst.push_back(1'b1); s_err.push_back(1'b1);
      end
      s_dat.push_back(frm[k]); s_vld.push_back(1'b1);
      s_lst.push_back(k == frm.size() - 1); s_err.push_back(k == err_at);
    end
  endtask

  task automatic add_frame(input int plen, input int corrupt_at, input int err_at, input int gap_at);
    frm.delete();
    for (int k = 0; k < plen; k++) frm.push_back(8'($urandom_range(0, 255)));
    append_fcs();
    if (corrupt_at >= 0) frm[corrupt_at] = frm[corrupt_at] ^ 8'($urandom_range(1, 255));
    append_frm(err_at, gap_at);
  endtask

  task automatic drive_stream();
    for (int i = 0; i < s_dat.size(); i++) begin
      @(negedge clk);
      din = s_dat[i]; vin = s_vld[i]; lin = s_lst[i]; ein = s_err[i];
    end
    @(negedge clk);
    vin = 1'b0; lin = 1'b0; ein = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_all();
    s_dat.delete(); s_vld.delete(); s_lst.delete(); s_err.delete();
    g_dat.delete(); g_lst.delete(); g_ok.delete(); g_le.delete();
    g_rx.delete(); g_len.delete(); g_co.delete();
  endtask

  // Frame-level model: payload is everything but the last four bytes; FCS is the
  // little-endian complement of the payload CRC.
  task automatic check_stream(input string tag);
    logic [7:0] cur [$];
    logic [7:0] e_dat [$];
    bit e_lst [$], e_ok [$], e_le [$], e_rx [$], e_co [$];
    int e_len [$];
    bit ef;
    int n, md, ns;
    bit ok;
    ef = 1'b0;
    for (int i = 0; i < s_dat.size(); i++) begin
      if (s_vld[i]) begin
        cur.push_back(s_dat[i]);
        ef = ef | s_err[i];
        if (s_lst[i]) begin
          n = cur.size();
          for (int k = 0; k < n - 4; k++) begin
            e_dat.push_back(cur[k]);
            e_lst.push_back(k == n - 5);
          end
          ok = (n >= 4) && ({cur[n-1], cur[n-2], cur[n-3], cur[n-4]} == fcs_q(cur, n - 4));
          e_ok.push_back(ok);
          e_le.push_back(n < MINF || n > MAXF);
          e_rx.push_back(ef);
          e_len.push_back(n > 65535 ? 65535 : n);
          e_co.push_back(n > 4);
          if ((!ok || n < MINF || n > MAXF || ef) && model_bad < 65535) model_bad++;
          cur.delete();
          ef = 1'b0;
        end
      end
    end
    chk({tag, "/ndata"}, g_dat.size(), e_dat.size());
    md = 0;
    for (int k = 0; k < g_dat.size() && k < e_dat.size(); k++)
      if (g_dat[k] !== e_dat[k] || g_lst[k] !== e_lst[k]) md++;
    chk({tag, "/data_last_mismatches"}, md, 0);
    chk({tag, "/nstatus"}, g_ok.size(), e_ok.size());
    ns = (g_ok.size() < e_ok.size()) ? g_ok.size() : e_ok.size();
    for (int k = 0; k < ns; k++) begin
      chk($sformatf("%s/f%0d/fcs_ok", tag, k), g_ok[k], e_ok[k]);
      chk($sformatf("%s/f%0d/len_err", tag, k), g_le[k], e_le[k]);
      chk($sformatf("%s/f%0d/rx_err", tag, k), g_rx[k], e_rx[k]);
      chk($sformatf("%s/f%0d/frame_len", tag, k), g_len[k], e_len[k]);
      chk($sformatf("%s/f%0d/last_with_status", tag, k), g_co[k], e_co[k]);
    end
    chk({tag, "/bad_count"}, o_bad_count, model_bad);
    clear_all();
  endtask

  initial begin
    int nl;
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      tbl[n] = c;
    end

    rst = 1'b1; din = 8'h00; vin = 1'b0; lin = 1'b0; ein = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/o_valid", o_valid, 0);
    chk("rst/o_last", o_last, 0);
    chk("rst/o_status_valid", o_status_valid, 0);
    chk("rst/o_fcs_ok", o_fcs_ok, 0);
    chk("rst/o_len_err", o_len_err, 0);
    chk("rst/o_rx_err", o_rx_err, 0);
    chk("rst/o_data", o_data, 0);
    chk("rst/o_frame_len", o_frame_len, 0);
    chk("rst/o_bad_count", o_bad_count, 0);
    rst = 1'b0;
    clear_all();

    // "123456789" with its published FCS
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    append_frm(-1, -1);
    drive_stream();
    chk("vec/fcs_ok_known", (g_ok.size() > 0) ? g_ok[0] : 1'b0, 1);
    chk("vec/len_known", (g_len.size() > 0) ? g_len[0] : 0, 13);
    check_stream("vec");

    frm[4] = 8'h36;
    append_frm(-1, -1);
    drive_stream();
    chk("vec_bad/fcs_ok_known", (g_ok.size() > 0) ? g_ok[0] : 1'b1, 0);
    check_stream("vec_bad");

    frm.delete();
    for (int k = 0; k < 60; k++) frm.push_back(8'(k));
    append_fcs();
    append_frm(-1, -1);
    drive_stream();
    check_stream("len64");

    add_frame(59, -1, -1, -1);
    drive_stream();
    check_stream("len63");

    add_frame(1514, -1, -1, -1);
    drive_stream();
    check_stream("len1518");

    add_frame(1515, -1, -1, -1);
    drive_stream();
    check_stream("len1519");

    add_frame(80, -1, -1, 10);
    add_frame(70, -1, -1, -1);
    drive_stream();
    check_stream("b2b");

    add_frame(70, -1, 4, -1);
    drive_stream();
    check_stream("err5");

    add_frame(70, -1, 73, -1);
    drive_stream();
    check_stream("err_on_last");

    frm = '{8'hAA};
    append_frm(-1, -1);
    add_frame(0, -1, -1, -1);
    add_frame(1, -1, -1, -1);
    drive_stream();
    check_stream("short");

    // reset during byte 21, which is also flagged last: reset must win
    add_frame(100, -1, -1, -1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      din = frm[k]; vin = 1'b1; lin = 1'b0; ein = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; din = frm[20]; vin = 1'b1; lin = 1'b1;
    @(negedge clk);
    rst = 1'b0; vin = 1'b0; lin = 1'b0;
    repeat (3) @(negedge clk);
    nl = 0;
    foreach (g_lst[k]) if (g_lst[k]) nl++;
    chk("abort/nstatus", g_ok.size(), 0);
    chk("abort/nlast", nl, 0);
    chk("abort/bad_cleared", o_bad_count, 0);
    model_bad = 0;
    clear_all();
    add_frame(100, -1, -1, -1);
    drive_stream();
    check_stream("after_abort");

    for (int f = 0; f < 25; f++) begin
      int plen;
      plen = $urandom_range(0, 90);
      add_frame(plen,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, plen + 3) : -1,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, plen + 3) : -1,
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, plen + 3) : -1);
    end
    drive_stream();
    check_stream("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_fcs_check.md
# rx_fcs_check

Receive-side Ethernet FCS checker and stripper; the counterpart of the transmit-side CRC-32 generator. Consumes a byte stream of one frame including its trailing 4-byte FCS, recomputes CRC-32 across all bytes, and forwards only the payload bytes. Emits a one-cycle per-frame status carrying the FCS, length and PCS-error verdicts. Sits between the RX PCS/deframer and the RX MAC client interface; there is no backpressure.

## Interface
- MIN_FRAME, 64, minimum legal frame length in bytes, FCS included
- MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included
- LEN_W, 16, width of the frame-length counter
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high; clock i_clk
- i_data  in  8  received byte, frame order, FCS last (FCS LSB-byte first)
- i_valid  in  1  i_data valid this cycle
- i_last  in  1  qualifies the final FCS byte of a frame; ignored when i_valid=0
- i_error  in  1  PCS error flag for this byte; ignored when i_valid=0
- o_data  out  8  payload byte, FCS stripped
- o_valid  out  1  o_data valid
- o_last  out  1  final payload byte of the frame
- o_status_valid  out  1  one-cycle strobe, frame verdict valid
- o_fcs_ok  out  1  FCS residue matched
- o_len_err  out  1  length < MIN_FRAME or > MAX_FRAME
- o_rx_err  out  1  i_error seen on any byte of the frame
- o_frame_len  out  LEN_W  bytes received including FCS, saturating
- o_bad_count  out  16  count of frames with any error, saturating

## Operation
- CRC register: reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF. Per accepted byte: crc <= (crc >> 8) ^ T[crc[7:0] ^ i_data], where T is the standard 256-entry byte table. A table or an equivalent XOR network is acceptable.
- Check: crc_next is the value after the i_last byte. o_fcs_ok = (crc_next == 32'hDEBB20E3), i.e. the good-frame residue with no final inversion.
- Strip buffer: a 4-byte shift register holds the most recent 4 bytes.
  - An accepted byte with 4 bytes already held pushes out the oldest byte to o_data and asserts o_valid.
  - o_last = i_last of the pushing byte.
  - The 4 bytes held at i_last are the FCS and are discarded.
- Occupancy counter 0..4 increments per accepted byte up to 4.
- Frames of ≤4 bytes produce no o_valid or o_last, but do produce status.
- Length counter counts accepted bytes including FCS and saturates at 2^LEN_W-1. The length check uses the count including the i_last byte.
- Error flag is sticky per frame: set by any valid byte with i_error=1, including the i_last byte.
- End of frame (i_valid & i_last): CRC, occupancy, length and error flag return to their initial state. The next accepted byte starts a new frame, so back-to-back frames need no idle cycle.
- o_bad_count increments on each status strobe with (!o_fcs_ok | o_len_err | o_rx_err) and holds at 0xFFFF.
- i_valid low mid-frame: all state holds and o_valid=0.

## Timing
- Outputs are registered.
- o_data/o_valid/o_last appear 1 cycle after the pushing input byte.
- Status appears 1 cycle after the i_last byte, in the same cycle as o_last (when o_last exists).
- o_status_valid is high for exactly 1 cycle. o_fcs_ok, o_len_err, o_rx_err and o_frame_len are meaningful only while it is high and hold their last values otherwise.
- Reset values:
  - o_valid, o_last, o_status_valid, o_fcs_ok, o_len_err, o_rx_err = 0.
  - o_data, o_frame_len, o_bad_count = 0.
  - CRC = 0xFFFFFFFF; occupancy and length = 0.
- Reset mid-frame: the partial frame is dropped, with no status and no o_last. Reset has priority over a simultaneous input byte.
- The i_last byte is also the first byte of a frame (1-byte frame): status asserted, o_len_err=1, o_frame_len=1.

## Test plan
- MIN_FRAME=1, frame bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB (last on CB):
  - o_data emits 31..39 with o_last on 39.
  - Status: o_fcs_ok=1, o_frame_len=13, o_len_err=0.
- Same frame with byte 35 changed to 36: payload forwarded unchanged; o_fcs_ok=0; o_bad_count goes 0→1.
- Default parameters, 60 payload bytes 00..3B plus correct FCS:
  - ok=1, len=64, len_err=0.
  - Repeat with 59 payload bytes: len_err=1.
- Two valid frames back-to-back with no gap, and i_valid toggling 1-0-1 inside the first:
  - Two o_last and two status strobes.
  - Both o_fcs_ok=1; no byte crosses frames.
- i_error=1 on byte 5 of a good-FCS frame: o_rx_err=1, o_fcs_ok=1, o_bad_count increments.
- i_reset at byte 20 of a frame, then a full good frame:
  - No status for the aborted frame.
  - Second frame ok=1 with the correct length.
